div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequencer and arbiter that shares one 32-bit iterative restoring divider (start/stop controlled, 32 iteration cycles) between NREQ requesters.
- Arbitrates requests round-robin and registers the operands.
- Drives the divider's start, iteration and stop phases, then returns quotient/rest with the requester id over a valid/ready response port.
- Sits between client blocks and the divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, width of rsp_id; must be ≥ clog2(NREQ)
- ITERS, 32, divider iteration cycles; fixed by the 32-bit datapath

Ports:
- clock  in  1  master clock
- reset  in  1  asynchronous reset, active high
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept, combinational, only in IDLE
- req_dividend  in  NREQ*32  flat; requester k at [32k+31:32k]
- req_divisor  in  NREQ*32  flat, same packing
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester the result belongs to
- rsp_quotient  out  32  quotient
- rsp_rest  out  32  remainder
- rsp_dbz  out  1  divide-by-zero flag (tied 0 unless feature enabled)
- busy  out  1  high in every state except IDLE
- div_start  out  1  to divider start
- div_stop  out  1  to divider stop
- div_dividend  out  32  to divider dividend
- div_divisor  out  32  to divider divisor
- div_quotient  in  32  from divider quotient
- div_rest  in  32  from divider rest

Behaviour:
- One clock, reset asynchronous active-high. Reset state:
  - state=IDLE, all registered outputs 0, operand registers 0, counter 0.
  - RR pointer=0, so requester 0 has highest priority first.
- States: IDLE, LOAD, ITER, STOP, RESP.
  - IDLE: if any req_valid, the grant goes to the first valid index at or after the pointer (wrap modulo NREQ).
    - req_ready[g]=1 that cycle. Capture dividend, divisor and id g.
    - Pointer ← (g+1) mod NREQ. Next state LOAD.
    - No req_valid → stay in IDLE.
  - LOAD: div_start=1 for exactly one cycle; counter←0; next ITER.
  - ITER: counter increments each cycle; at counter==ITERS-1 → STOP (ITERS cycles total).
  - STOP: div_stop=1 for exactly one cycle; next RESP.
  - RESP: rsp_valid=1, with rsp_quotient=div_quotient and rsp_rest=div_rest passed through. The divider output registers hold because stop is low.
    - On rsp_valid&&rsp_ready → IDLE.
- div_dividend and div_divisor are driven from the operand registers at all times.
  - The divisor must stay stable from LOAD through STOP, because the divider subtracts the live divisor input.
- Latency: acceptance at cycle 0 → rsp_valid first high at cycle 35 (LOAD 1, ITER 32, STOP 1). Throughput is at most one op per 36 cycles (RESP→IDLE costs one cycle; no accept in RESP).
- Backpressure: rsp_ready low holds RESP; rsp_* stay stable and no new request is accepted.
- Simultaneous requests: exactly one grant per IDLE cycle; the losers keep req_valid and are served in RR order. Requesters must hold operands stable while req_valid is high and unaccepted.
- Reset during any state: immediate return to IDLE; in-flight op discarded with no response. The divider shares the reset net.
- Divisor 0 with feature off: the divider result is returned unmodified (quotient 0xFFFFFFFF, rest undefined-by-design); rsp_dbz=0.

Optional Feature:
- DIV_ZERO_BYPASS_EN defined:
  - An accepted divisor of 0 goes IDLE→RESP directly; no div_start/div_stop pulses.
  - Response: quotient=32'hFFFFFFFF, rest=captured dividend (from the operand register), rsp_dbz=1.
  - Latency 1 cycle after acceptance.
- Not defined: rsp_dbz is tied 0 and every op runs through the divider.

Decomposition:
- Package div_ctrl_pkg:
  - state enum/encoding (IDLE, LOAD, ITER, STOP, RESP)
  - DIV_ITERS=32, DIV_W=32
  - DBZ_QUOTIENT=32'hFFFFFFFF
- Sub-module div_rr_arbiter(NREQ): req vector + pointer in → one-hot grant, grant index, any-grant flag. Purely combinational; pointer register stays in div_seq_ctrl.

Test Plan:
- Req0 100/7, rsp_ready=1 → rsp_valid at cycle 35 after accept, quotient=14, rest=2, id=0; div_start and div_stop each exactly one pulse, 33 cycles apart.
- 32'hFFFFFFFF/1 and 5/9 → quotient=FFFFFFFF rest=0; quotient=0 rest=5.
- Req1, req2, req3 valid together with pointer 0 → grants in order 1, 2, 3, ids match; then req0 and req3 together → 0 first.
- rsp_ready low for 10 cycles in RESP → rsp_* constant, busy=1, req_ready all 0; op completes when ready rises.
- Reset asserted mid-ITER (cycle 15) → outputs 0 asynchronously, state IDLE, no rsp_valid; next request completes normally.
- Divisor 0, dividend 1234 → with DIV_ZERO_BYPASS_EN: rsp_valid one cycle after accept, quotient FFFFFFFF, rest 1234, rsp_dbz=1, no div_start; without the macro: 35-cycle path, rsp_dbz=0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider sequencer: FSM states and datapath constants.
package div_ctrl_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_STOP,
    ST_RESP
  } div_state_e;

endpackage

// File: rtl/div_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module div_rr_arbiter
  import div_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  // One extra bit so ptr+i never overflows before the modulo wrap.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any_gnt && req[cand]) begin
        any_gnt = 1'b1;
        gnt_idx = cand;
      end
    end
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer/arbiter sharing one iterative restoring divider among NREQ requesters.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero requests
// directly (quotient all ones, rest = dividend, rsp_dbz set) without the divider.
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int ITERS = DIV_ITERS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIV_W-1:0] req_dividend,
  input  logic [NREQ*DIV_W-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DIV_W-1:0]      rsp_quotient,
  output logic [DIV_W-1:0]      rsp_rest,
  output logic                  rsp_dbz,
  output logic                  busy,
  output logic                  div_start,
  output logic                  div_stop,
  output logic [DIV_W-1:0]      div_dividend,
  output logic [DIV_W-1:0]      div_divisor,
  input  logic [DIV_W-1:0]      div_quotient,
  input  logic [DIV_W-1:0]      div_rest
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(ITERS);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [DIV_W-1:0] dividend_q, dividend_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
`ifdef DIV_ZERO_BYPASS_EN
  logic             dbz_q, dbz_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_gnt;
  logic [DIV_W-1:0] sel_dividend, sel_divisor;

  div_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Grants are only offered while idle; the accept is visible the same cycle.
  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

  // Pick the granted requester's operands out of the flat buses.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_dividend = sel_dividend | req_dividend[k*DIV_W +: DIV_W];
        sel_divisor  = sel_divisor  | req_divisor[k*DIV_W +: DIV_W];
      end
    end
  end

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    dbz_d      = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_gnt) begin
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          id_d       = ID_W'(gnt_idx);
          ptr_d      = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_divisor == '0) begin
            state_d = ST_RESP;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
            start_d = 1'b1;
            dbz_d   = 1'b0;
          end
`else
          state_d = ST_LOAD;
          start_d = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (cnt_q == CNT_W'(ITERS-1)) begin
          state_d = ST_STOP;
          stop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand and pulse registers; reset discards any in-flight op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      id_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = id_q;
  assign div_start    = start_q;
  assign div_stop     = stop_q;
  // The divider reads the live divisor every iteration, so it comes straight from the register.
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

`ifdef DIV_ZERO_BYPASS_EN
  assign rsp_quotient = !rsp_valid ? '0 : (dbz_q ? DBZ_QUOTIENT : div_quotient);
  assign rsp_rest     = !rsp_valid ? '0 : (dbz_q ? dividend_q : div_rest);
  assign rsp_dbz      = rsp_valid & dbz_q;
`else
  assign rsp_quotient = rsp_valid ? div_quotient : '0;
  assign rsp_rest     = rsp_valid ? div_rest : '0;
  assign rsp_dbz      = 1'b0;
`endif

endmodule
